// File: rtl/data_memory_arbiter.sv
// ============================================================================
//  Module   : data_memory_arbiter
//  Brief    : Round-robin arbiter sharing one DataMemory between an I-side
//             (port 0) and a D-side (port 1) requester. Optional WAIT-state
//             abort is enabled by defining MEM_ARB_TIMEOUT_EN.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module data_memory_arbiter #(
    parameter int pBlockSize = 32,
    parameter int pTimeout   = 15
) (
    input  logic                    clk_i,
    input  logic                    rst_i,

    input  logic                    p0_req_i,
    input  logic                    p0_we_i,
    input  logic [31:0]             p0_addr_i,
    input  logic [pBlockSize*8-1:0] p0_wdata_i,
    output logic [pBlockSize*8-1:0] p0_rdata_o,
    output logic                    p0_ack_o,

    input  logic                    p1_req_i,
    input  logic                    p1_we_i,
    input  logic [31:0]             p1_addr_i,
    input  logic [pBlockSize*8-1:0] p1_wdata_i,
    output logic [pBlockSize*8-1:0] p1_rdata_o,
    output logic                    p1_ack_o,

    output logic                    mem_enable_o,
    output logic [31:0]             mem_addr_o,
    output logic                    mem_we_o,
    output logic [pBlockSize*8-1:0] mem_wdata_o,
    input  logic [pBlockSize*8-1:0] mem_rdata_i,
    input  logic                    mem_ack_i,

    output logic                    owner_o,
    output logic                    busy_o,
    output logic                    timeout_o
);

    localparam int         c_DW      = pBlockSize * 8;
    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_ISSUE   = 2'd1;
    localparam logic [1:0] S_WAIT    = 2'd2;
    localparam logic [1:0] S_DONE    = 2'd3;

    logic [1:0]      r_state;
    logic [1:0]      w_next;
    logic            r_owner;
    logic            r_mem_enable;
    logic [31:0]     r_mem_addr;
    logic            r_mem_we;
    logic [c_DW-1:0] r_mem_wdata;
    logic [c_DW-1:0] r_p0_rdata;
    logic [c_DW-1:0] r_p1_rdata;
    logic            r_p0_ack;
    logic            r_p1_ack;
    logic            r_timeout;

    logic            w_grant;
    logic            w_winner;
    logic            w_complete;
    logic            w_abort;
    logic            w_to_hit;

`ifdef MEM_ARB_TIMEOUT_EN
    localparam logic [3:0] c_TIMEOUT = 4'(pTimeout);
    logic [3:0] r_to_cnt;

    assign w_to_hit = (r_to_cnt == c_TIMEOUT) && !mem_ack_i;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_to_cnt <= 4'd0;
        end else if (r_state == S_ISSUE) begin
            r_to_cnt <= 4'd0;
        end else if (r_state == S_WAIT && !mem_ack_i && !w_to_hit) begin
            r_to_cnt <= r_to_cnt + 4'd1;
        end
    end
`else
    assign w_to_hit = 1'b0;
`endif

    // State register
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (p0_req_i || p1_req_i) w_next = S_ISSUE;
            S_ISSUE: w_next = S_WAIT;
            S_WAIT:  if (mem_ack_i || w_to_hit) w_next = S_DONE;
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // Output decode; on a tie the port that was not served last wins
    always_comb begin
        w_grant    = (r_state == S_IDLE) && (p0_req_i || p1_req_i);
        w_winner   = (p0_req_i && p1_req_i) ? !r_owner : p1_req_i;
        w_complete = (r_state == S_WAIT) && mem_ack_i;
        w_abort    = (r_state == S_WAIT) && w_to_hit;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_owner      <= 1'b1;
            r_mem_enable <= 1'b0;
            r_mem_addr   <= 32'd0;
            r_mem_we     <= 1'b0;
            r_mem_wdata  <= '0;
            r_p0_rdata   <= '0;
            r_p1_rdata   <= '0;
            r_p0_ack     <= 1'b0;
            r_p1_ack     <= 1'b0;
            r_timeout    <= 1'b0;
        end else begin
            r_mem_enable <= w_grant;
            r_p0_ack     <= 1'b0;
            r_p1_ack     <= 1'b0;
            r_timeout    <= 1'b0;
            if (w_grant) begin
                r_owner     <= w_winner;
                r_mem_addr  <= w_winner ? p1_addr_i  : p0_addr_i;
                r_mem_we    <= w_winner ? p1_we_i    : p0_we_i;
                r_mem_wdata <= w_winner ? p1_wdata_i : p0_wdata_i;
            end
            if (w_complete || w_abort) begin
                r_p0_ack  <= !r_owner;
                r_p1_ack  <= r_owner;
                r_timeout <= w_abort;
            end
            // Writes and aborts leave the requester's read data untouched
            if (w_complete && !r_mem_we) begin
                if (r_owner) begin
                    r_p1_rdata <= mem_rdata_i;
                end else begin
                    r_p0_rdata <= mem_rdata_i;
                end
            end
        end
    end

    assign busy_o       = (r_state != S_IDLE);
    assign owner_o      = r_owner;
    assign mem_enable_o = r_mem_enable;
    assign mem_addr_o   = r_mem_addr;
    assign mem_we_o     = r_mem_we;
    assign mem_wdata_o  = r_mem_wdata;
    assign p0_rdata_o   = r_p0_rdata;
    assign p1_rdata_o   = r_p1_rdata;
    assign p0_ack_o     = r_p0_ack;
    assign p1_ack_o     = r_p1_ack;
    assign timeout_o    = r_timeout;

endmodule

`default_nettype wire
